// File: rtl/pp_pipeline_accel_resize_coord_sched.sv
// Resize source-coordinate scheduler: issues output indices to the scale pipeline, tracks
// in-flight results through its ce-stalled latency, clamps and streams (int, frac) downstream.
module pp_pipeline_accel_resize_coord_sched #(
    parameter int unsigned IDX_W   = 20,
    parameter int unsigned SCALE_W = 48,
    parameter int unsigned RES_W   = 42,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned LATENCY = 6
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [IDX_W-1:0]   cfg_count,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [IDX_W-1:0]   cfg_in_size,
    output logic [31:0]        cmp_index,
    output logic [SCALE_W-1:0] cmp_scale,
    output logic               cmp_ce,
    input  logic [RES_W-1:0]   cmp_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_int,
    output logic [FRAC_W-1:0]  out_frac,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    // Number of fraction bits in the pipeline result (22 for Q20.22).
    localparam int unsigned FixW = RES_W - IDX_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     count_q, count_d;
    logic [SCALE_W-1:0]   scale_q, scale_d;
    logic [IDX_W-1:0]     clamp_max_q, clamp_max_d;
    logic [IDX_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]     out_cnt_q, out_cnt_d;
    logic [LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic                 out_valid_q, out_valid_d;
    logic [IDX_W-1:0]     out_int_q, out_int_d;
    logic [FRAC_W-1:0]    out_frac_q, out_frac_d;
    logic                 out_last_q, out_last_d;

    logic                 active;
    logic                 ce;
    logic                 capture;
    logic [IDX_W-1:0]     count_m1;
    logic [IDX_W-1:0]     res_int;
    logic [FRAC_W-1:0]    res_frac;
    logic [IDX_W-1:0]     clamp_int;
    logic [FRAC_W-1:0]    clamp_frac;

    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign ce       = active && (!out_valid_q || out_ready);
    assign capture  = ce && vld_sr_q[LATENCY-1];
    assign count_m1 = count_q - IDX_W'(1);
    assign res_int  = cmp_result[FixW +: IDX_W];
    assign res_frac = cmp_result[FixW-1 -: FRAC_W];

    always_comb begin
        clamp_int  = res_int;
        clamp_frac = res_frac;
        if (cmp_result[RES_W-1]) begin
            clamp_int  = '0;
            clamp_frac = '0;
        end else if (res_int >= clamp_max_q) begin
            clamp_int  = clamp_max_q;
            clamp_frac = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        scale_d     = scale_q;
        clamp_max_d = clamp_max_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        vld_sr_d    = vld_sr_q;
        out_valid_d = out_valid_q;
        out_int_d   = out_int_q;
        out_frac_d  = out_frac_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    count_d     = cfg_count;
                    scale_d     = cfg_scale;
                    // in_size of 0 behaves like 1, so the clamp limit is 0 either way.
                    clamp_max_d = (cfg_in_size == '0) ? '0 : cfg_in_size - IDX_W'(1);
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    vld_sr_d    = '0;
                    state_d     = (cfg_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (ce) begin
                    vld_sr_d    = (vld_sr_q << 1) | LATENCY'(1);
                    issue_cnt_d = issue_cnt_q + IDX_W'(1);
                    if (issue_cnt_q == count_m1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (ce) begin
                    vld_sr_d = vld_sr_q << 1;
                end
                if ((vld_sr_q == '0) && out_valid_q && out_ready && out_last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Capture wins over a plain accept so a back-to-back handoff keeps out_valid high.
        if (capture) begin
            out_valid_d = 1'b1;
            out_int_d   = clamp_int;
            out_frac_d  = clamp_frac;
            out_last_d  = (out_cnt_q == count_m1);
            out_cnt_d   = out_cnt_q + IDX_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            scale_q     <= '0;
            clamp_max_q <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            vld_sr_q    <= '0;
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_frac_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            scale_q     <= scale_d;
            clamp_max_q <= clamp_max_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            vld_sr_q    <= vld_sr_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_frac_q  <= out_frac_d;
            out_last_q  <= out_last_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign cmp_index   = 32'(issue_cnt_q);
    assign cmp_scale   = scale_q;
    assign cmp_ce      = ce;
    assign out_valid   = out_valid_q;
    assign out_int     = out_int_q;
    assign out_frac    = out_frac_q;
    assign out_last    = out_last_q;

endmodule
